// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read-side arbiter.
package fifo_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      cand = IW'((32'(last) + k) % NREQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter draining several FIFO read sides into one output register.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic [NREQ-1:0]         empty,
  input  logic [NREQ*DSIZE-1:0]   rdata,
  output logic [NREQ-1:0]         rinc,
  output logic                    out_valid,
  output logic [DSIZE-1:0]        out_data,
  output logic [$clog2(NREQ)-1:0] out_src,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    g, last;
  logic [CW-1:0]    beat_cnt;
  logic             any;
  logic [IW-1:0]    pick;
  logic             beat;
  logic             to_idle;
  logic [DSIZE-1:0] rword [NREQ];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (~empty),
    .last (last),
    .any  (any),
    .idx  (pick)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      rword[i] = rdata[i*DSIZE +: DSIZE];
    end
  end

  assign beat    = (state == GRANT) && !empty[g] && (!out_valid || out_ready);
  assign to_idle = (state != IDLE) && (state_nxt == IDLE);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = GRANT;
      GRANT: begin
        if (empty[g]) begin
          state_nxt = IDLE;
        end else if (beat) begin
          state_nxt = (beat_cnt == BURST_LAST) ? IDLE : GAP;
        end
      end
      GAP:     state_nxt = GRANT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rinc = '0;
    if (beat && !rrst) begin
      rinc[g] = 1'b1;
    end
  end

  // Ending a grant clears the counter even on the burst-completing beat.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      g         <= '0;
      last      <= IW'(NREQ - 1);
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      busy      <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        g <= pick;
      end
      if (to_idle) begin
        last     <= g;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (beat) begin
        out_valid <= 1'b1;
        out_data  <= rword[g];
        out_src   <= g;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench: FIFO models feed the arbiter; expected output order is derived from queue contents.
module tb_fifo_rd_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic                  rclk = 1'b0;
  logic                  rrst = 1'b1;
  logic [NREQ-1:0]       empty = '1;
  logic [NREQ*DSIZE-1:0] rdata = '0;
  logic [NREQ-1:0]       rinc;
  logic                  out_valid;
  logic [DSIZE-1:0]      out_data;
  logic [1:0]            out_src;
  logic                  out_ready = 1'b1;
  logic                  busy;

  fifo_rd_arbiter #(
    .NREQ  (NREQ),
    .DSIZE (DSIZE),
    .BURST (BURST)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .empty     (empty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int src;
    int data;
  } exp_t;

  logic [DSIZE-1:0] fq [NREQ][$];
  exp_t             exp_q[$];
  int               pop_src[$];
  int               pop_cyc[$];
  int               cyc = 0;
  int               nchk = 0;
  int               nerr = 0;
  logic [NREQ-1:0]  prev_rinc = '0;

  task automatic chk(input string name, input int got, input int req);
    nchk++;
    if (got != req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // FIFO read-side models: pop on rinc, registered empty and head word.
  always @(posedge rclk) begin
    logic [NREQ*DSIZE-1:0] rd_n;
    logic [NREQ-1:0]       em_n;
    cyc = cyc + 1;
    nchk++;
    if ((rinc & prev_rinc) != '0 || $countones(rinc) > 1) begin
      nerr++;
      $display("FAIL pop_rate: rinc %b after %b, required one-hot and non-consecutive", rinc, prev_rinc);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rinc[i]) begin
        if (fq[i].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL underflow: rinc[%0d] on empty FIFO, required no pop", i);
        end else begin
          pop_src.push_back(i);
          pop_cyc.push_back(cyc);
          void'(fq[i].pop_front());
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      em_n[i] = (fq[i].size() == 0);
      rd_n[i*DSIZE +: DSIZE] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
    empty     <= em_n;
    rdata     <= rd_n;
    prev_rinc  = rinc;
  end

  always @(negedge rclk) begin
    if (!rrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_output: got src %0d data %0h, required none", out_src, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_src", int'(out_src), e.src);
        chk("out_data", int'(out_data), e.data);
      end
    end
  end

  // Expected stream: round-robin from FIFO 0, each grant takes min(BURST, words left).
  task automatic build_expect();
    int rd[NREQ];
    int last, total, c, n;
    bit found;
    last  = NREQ - 1;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = 0;
      total += fq[i].size();
    end
    while (total > 0) begin
      found = 0;
      c = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && (fq[(last + k) % NREQ].size() - rd[(last + k) % NREQ]) > 0) begin
          found = 1;
          c = (last + k) % NREQ;
        end
      end
      n = fq[c].size() - rd[c];
      if (n > BURST) n = BURST;
      for (int j = 0; j < n; j++) begin
        exp_t e;
        e.src  = c;
        e.data = int'(fq[c][rd[c] + j]);
        exp_q.push_back(e);
      end
      rd[c] += n;
      total -= n;
      last = c;
    end
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    rrst = 1'b1;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge rclk); #1;
    end
    rrst = 1'b0;
    exp_q.delete();
    pop_src.delete();
    pop_cyc.delete();
  endtask

  function automatic int fifo_words();
    int t = 0;
    for (int i = 0; i < NREQ; i++) t += fq[i].size();
    return t;
  endfunction

  task automatic drain(input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid || fifo_words() != 0) && n < 3000) begin
      @(posedge rclk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", (n >= 3000) ? 1 : 0, 0);
    chk("fifo_left", fifo_words(), 0);
  endtask

  task automatic wait_pops(input int cnt);
    int n = 0;
    while (pop_src.size() < cnt && n < 50) begin
      @(posedge rclk); #1;
      n++;
    end
    chk("pop_wait_timeout", (n >= 50) ? 1 : 0, 0);
  endtask

  initial begin
    int exp_src[12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
    logic [DSIZE-1:0] held;
    int base;

    rrst = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_src", int'(out_src), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rinc", int'(rinc), 0);
    rrst = 1'b0;

    // Single source
    do_reset();
    fq[1].push_back(8'hA1);
    fq[1].push_back(8'hA2);
    build_expect();
    drain(0);
    chk("single_pops", pop_src.size(), 2);
    if (pop_src.size() == 2) begin
      chk("single_src0", pop_src[0], 1);
      chk("single_src1", pop_src[1], 1);
      chk("single_gap", pop_cyc[1] - pop_cyc[0], 2);
    end
    chk("single_busy_after", int'(busy), 0);

    // Burst limit and rotation
    do_reset();
    for (int j = 0; j < 6; j++) begin
      fq[0].push_back(DSIZE'(8'h00 + j));
      fq[2].push_back(DSIZE'(8'h20 + j));
    end
    build_expect();
    drain(0);
    chk("burst_pops", pop_src.size(), 12);
    if (pop_src.size() == 12) begin
      for (int j = 0; j < 12; j++) chk("burst_order", pop_src[j], exp_src[j]);
    end

    // Fairness with every FIFO busy
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++) fq[i].push_back(DSIZE'(16 * i + j));
    build_expect();
    drain(0);
    chk("fair_pops", pop_src.size(), 32);
    if (pop_src.size() == 32) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int j = 0; j < 4; j++) chk("fair_src", pop_src[4 * k + j], k);
        chk("fair_span", pop_cyc[4 * k + 3] - pop_cyc[4 * k], 6);
      end
    end

    // Backpressure
    do_reset();
    for (int j = 0; j < 4; j++) fq[3].push_back(DSIZE'(8'hC0 + j));
    build_expect();
    wait_pops(1);
    out_ready = 1'b0;
    held = out_data;
    chk("bp_first_data", int'(held), 8'hC0);
    repeat (5) begin
      @(negedge rclk);
      chk("bp_rinc_zero", int'(rinc), 0);
      chk("bp_data_hold", int'(out_data), int'(held));
      @(posedge rclk); #1;
    end
    out_ready = 1'b1;
    @(negedge rclk);
    chk("bp_resume_beat", int'(rinc), 4'b1000);
    drain(0);

    // Reset during GAP
    do_reset();
    for (int j = 0; j < 4; j++) begin
      fq[0].push_back(DSIZE'(8'h50 + j));
      fq[1].push_back(DSIZE'(8'h60 + j));
    end
    build_expect();
    wait_pops(2);
    rrst = 1'b1;
    @(negedge rclk);
    chk("rst_mid_rinc_during", int'(rinc), 0);
    @(posedge rclk); #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rinc", int'(rinc), 0);
    exp_q.delete();
    @(posedge rclk); #1;
    rrst = 1'b0;
    base = pop_src.size();
    build_expect();
    drain(0);
    if (pop_src.size() > base) chk("rst_mid_first_src", pop_src[base], 0);
    else chk("rst_mid_no_pop", pop_src.size(), base + 1);

    // Random contents with random backpressure
    for (int it = 0; it < 30; it++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        int n = $urandom_range(0, 9);
        for (int j = 0; j < n; j++) fq[i].push_back(DSIZE'($urandom));
      end
      build_expect();
      drain(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4: number of FIFO read sides.
- DSIZE, default 8: data width.
- BURST, default 4: maximum beats per grant.
REQ-002 Ports (name, direction, width, meaning):
- rclk, in, 1: single clock, shared with every FIFO read side.
- rrst, in, 1: synchronous, active-high reset.
- empty, in, NREQ: per-FIFO registered empty flag.
- rdata, in, NREQ*DSIZE: per-FIFO read data; slice i holds FIFO i's current word, combinational from its raddr.
- rinc, out, NREQ: per-FIFO pop strobe.
- out_valid, out, 1: output word held in the output register.
- out_data, out, DSIZE: output word.
- out_src, out, clog2(NREQ): index of the FIFO that supplied out_data.
- out_ready, in, 1: downstream accepts the word.
- busy, out, 1: a grant is active.
REQ-003 The clock SHALL be rclk and the reset SHALL be rrst; reset is synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, GRANT and GAP.
REQ-005 In IDLE, if any empty[i]==0, the next grant g SHALL be the first non-empty index searched round-robin from last+1 modulo NREQ; the FSM SHALL enter GRANT on the next edge (1-cycle arbitration latency). Otherwise it SHALL stay in IDLE.
REQ-006 Pop condition: in GRANT, a beat SHALL occur when empty[g]==0 and (out_valid==0 or out_ready==1).
REQ-007 On a beat, rinc[g] SHALL be 1 for exactly that cycle and all other rinc bits SHALL be 0. On the same edge, out_data SHALL load rdata slice g, out_src SHALL load g and out_valid SHALL be set.
REQ-008 out_valid SHALL clear on an edge where out_valid==1, out_ready==1 and no beat occurs.
REQ-009 out_data and out_src SHALL hold while out_valid==1 and out_ready==0.
REQ-010 The empty flag lags a pop by one cycle. After a beat, the FSM SHALL go to GAP for exactly one cycle with rinc all-zero, then return to GRANT. No FIFO SHALL be popped on two consecutive cycles.
REQ-011 A beat counter (width clog2(BURST)+1) SHALL count beats in the current grant. When the beat that brings the count to BURST is taken, the FSM SHALL go to IDLE instead of GAP.
REQ-012 In GRANT with empty[g]==1, the FSM SHALL go to IDLE with no beat, ending the grant early.
REQ-013 On every transition to IDLE, last SHALL be set to g and the beat counter SHALL clear. The maximum wait for any non-empty FIFO is (NREQ-1) grants.
REQ-014 If the downstream stalls in GRANT (out_valid==1, out_ready==0), the FSM SHALL hold in GRANT with no rinc and the beat count unchanged.
REQ-015 busy SHALL be 1 in GRANT and GAP, and 0 in IDLE.
REQ-016 empty changes on non-granted FIFOs SHALL NOT affect a grant in progress.

Reset
REQ-017 When rrst==1 at an edge, the block SHALL reset to: state IDLE; last=NREQ-1, so FIFO 0 has first priority; beat count=0; out_valid=0; out_data=0; out_src=0.
REQ-018 While rrst==1, rinc SHALL be all-zero and busy SHALL be 0, including when reset is asserted mid-grant.
REQ-019 The first grant SHALL be possible at the second edge after rrst deasserts.

Structure
REQ-020 Package fifo_pkg SHALL hold the state enum type and the default NREQ, DSIZE and BURST constants.
REQ-021 The round-robin picker SHALL be a sub-module rr_pick: inputs req[NREQ] and last; outputs any and idx. It SHALL be purely combinational.
REQ-022 Pop strobes SHALL be decoded combinationally from state, g, empty and out_ready. All other outputs SHALL be registered.

Verification
REQ-023 Single source:
- Stimulus: FIFO1 holds 2 words (0xA1, 0xA2); others empty; out_ready=1.
- Response: rinc[1] pulses on 2 cycles separated by 1 GAP cycle; outputs 0xA1 then 0xA2 with out_src=1; grant ends on empty; busy=0 afterwards.
REQ-024 Burst limit and rotation:
- Stimulus: FIFO0 and FIFO2 each hold 6 words; out_ready=1.
- Response: 4 beats from FIFO0, then 4 from FIFO2, then 2 from FIFO0, then 2 from FIFO2.
REQ-025 Backpressure:
- Stimulus: out_ready=0 for 5 cycles after the first beat.
- Response: out_data held stable; rinc all-zero throughout; the next beat occurs in the cycle out_ready returns to 1.
REQ-026 Reset mid-grant:
- Stimulus: assert rrst during GAP.
- Response: next cycle out_valid=0, busy=0, rinc=0; after release, FIFO0 wins if it is non-empty.
REQ-027 Fairness:
- Stimulus: all 4 FIFOs always non-empty.
- Response: grant order 0,1,2,3,0...; each grant delivers 4 beats in 7 cycles.
REQ-028 Pop-rate check:
- Stimulus: random traffic for 10k cycles.
- Response: assertion that no rinc bit is high on consecutive cycles and that at most one rinc bit is high at any time.
